seg7_scan: RTL and testbench

Multiplexed hex seven-segment display driver. It is the output-side counterpart of the debounced button inputs on the same board.
- Takes a packed value, per-digit decimal points and per-digit blank flags.
- Time-multiplexes them onto shared segment lines and per-digit anode enables.
- Updates are double-buffered and applied only at frame boundaries, so a frame never shows a mix of old and new digits.

---
 rtl/seg7_pkg.sv | 17 +
 rtl/seg7_scan_hex7_decode.sv | 11 +
 rtl/seg7_scan.sv | 118 +++++++++++
 tb/tb_seg7_scan.sv | 178 +++++++++++++++++
 4 files changed

// File: rtl/seg7_pkg.sv
// Shared constants for the multiplexed seven-segment driver: hex glyph table,
// the logical "all segments off" pattern and the digit-index width helper.
package seg7_pkg;

    localparam logic [6:0] SEG_OFF = 7'h00;

    // On-bits {g,f,e,d,c,b,a} for hex digits 0..F
    localparam logic [6:0] HEX7 [16] = '{
        7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
        7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
    };

    function automatic int idx_width(input int digits);
        return (digits > 1) ? $clog2(digits) : 1;
    endfunction

endpackage

// File: rtl/seg7_scan_hex7_decode.sv
// Combinational hex nibble to seven-segment on-pattern; polarity is applied by the caller.
module hex7_decode
    import seg7_pkg::*;
(
    input  logic [3:0] nibble,
    output logic [6:0] pattern
);

    assign pattern = HEX7[nibble];

endmodule

// File: rtl/seg7_scan.sv
// Multiplexed hex display driver with frame-aligned double buffering of the
// displayed value, decimal points and blank flags.
module seg7_scan
    import seg7_pkg::*;
#(
    parameter int DIGITS     = 4,
    parameter int PRESCALE   = 50000,
    parameter bit ACTIVE_LOW = 1'b1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  load,
    input  logic [4*DIGITS-1:0]   value,
    input  logic [DIGITS-1:0]     dp,
    input  logic [DIGITS-1:0]     blank,
    output logic [DIGITS-1:0]     an,
    output logic [6:0]            seg,
    output logic                  seg_dp,
    output logic                  frame,
    output logic                  pending
);

    localparam int CW = $clog2(PRESCALE);
    localparam int IW = idx_width(DIGITS);
    localparam logic [CW-1:0]     CNT_LAST = CW'(PRESCALE - 1);
    localparam logic [IW-1:0]     IDX_LAST = IW'(DIGITS - 1);
    localparam logic [DIGITS-1:0] AN_POL   = {DIGITS{ACTIVE_LOW}};
    localparam logic [6:0]        SEG_POL  = {7{ACTIVE_LOW}};

    logic [CW-1:0]         cnt;
    logic [IW-1:0]         idx;
    logic [4*DIGITS-1:0]   disp_value, pend_value;
    logic [DIGITS-1:0]     disp_dp, pend_dp;
    logic [DIGITS-1:0]     disp_blank, pend_blank;

    logic                  slot_end;
    logic                  boundary;
    logic [3:0]            cur_nibble;
    logic                  cur_dp;
    logic                  cur_blank;
    logic [DIGITS-1:0]     cur_onehot;
    logic [6:0]            cur_pattern;

    assign slot_end = (cnt == CNT_LAST);
    assign boundary = slot_end && (idx == IDX_LAST);

    // Explicit compare-based mux so non-power-of-two DIGITS never indexes out of range
    always_comb begin
        cur_nibble = 4'h0;
        cur_dp     = 1'b0;
        cur_blank  = 1'b1;
        cur_onehot = '0;
        for (int i = 0; i < DIGITS; i++) begin
            if (idx == IW'(i)) begin
                cur_nibble    = disp_value[4*i +: 4];
                cur_dp        = disp_dp[i];
                cur_blank     = disp_blank[i];
                cur_onehot[i] = 1'b1;
            end
        end
    end

    hex7_decode u_decode (
        .nibble  (cur_nibble),
        .pattern (cur_pattern)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt        <= '0;
            idx        <= '0;
            disp_value <= '0;
            disp_dp    <= '0;
            disp_blank <= '1;
            pend_value <= '0;
            pend_dp    <= '0;
            pend_blank <= '1;
            pending    <= 1'b0;
            frame      <= 1'b0;
            an         <= AN_POL;
            seg        <= SEG_OFF ^ SEG_POL;
            seg_dp     <= ACTIVE_LOW;
        end else begin
            cnt <= slot_end ? '0 : cnt + 1'b1;
            if (slot_end)
                idx <= (idx == IDX_LAST) ? '0 : idx + 1'b1;
            frame <= boundary;

            if (load) begin
                pend_value <= value;
                pend_dp    <= dp;
                pend_blank <= blank;
            end

            // A load landing on the boundary bypasses the buffer and takes effect now
            if (boundary) begin
                pending <= 1'b0;
                if (load) begin
                    disp_value <= value;
                    disp_dp    <= dp;
                    disp_blank <= blank;
                end else if (pending) begin
                    disp_value <= pend_value;
                    disp_dp    <= pend_dp;
                    disp_blank <= pend_blank;
                end
            end else if (load) begin
                pending <= 1'b1;
            end

            // First cycle of each slot keeps anodes off to avoid ghosting between digits
            an     <= ((cnt == '0 || cur_blank) ? '0 : cur_onehot) ^ AN_POL;
            seg    <= cur_pattern ^ SEG_POL;
            seg_dp <= cur_dp ^ ACTIVE_LOW;
        end
    end

endmodule

// File: tb/tb_seg7_scan.sv
// Bench for seg7_scan (DIGITS=4, PRESCALE=4, ACTIVE_LOW=1): cycle-count reference
// model plus a glyph table and directed/random load sequences.
module tb_seg7_scan;

    logic        clk = 1'b0;
    logic        rst;
    logic        load;
    logic [15:0] value;
    logic [3:0]  dp;
    logic [3:0]  blank;
    logic [3:0]  an;
    logic [6:0]  seg;
    logic        seg_dp;
    logic        frame;
    logic        pending;

    int checks = 0;
    int failures = 0;

    // reference model: absolute cycle number since reset plus shown/queued data
    int          t;
    logic [15:0] m_value, p_value;
    logic [3:0]  m_dp, p_dp, m_blank, p_blank;
    logic        m_pend;

    typedef struct {
        logic [3:0] nib;
        logic [6:0] seg_n;
    } vec_t;
    vec_t vecs [16];

    seg7_scan #(.DIGITS(4), .PRESCALE(4), .ACTIVE_LOW(1'b1)) dut (
        .clk     (clk),
        .rst     (rst),
        .load    (load),
        .value   (value),
        .dp      (dp),
        .blank   (blank),
        .an      (an),
        .seg     (seg),
        .seg_dp  (seg_dp),
        .frame   (frame),
        .pending (pending)
    );

    always #5 clk = ~clk;

    function automatic logic [6:0] glyph_on(input logic [3:0] n);
        case (n)
            4'h0: return 7'h3F;  4'h1: return 7'h06;  4'h2: return 7'h5B;  4'h3: return 7'h4F;
            4'h4: return 7'h66;  4'h5: return 7'h6D;  4'h6: return 7'h7D;  4'h7: return 7'h07;
            4'h8: return 7'h7F;  4'h9: return 7'h6F;  4'hA: return 7'h77;  4'hB: return 7'h7C;
            4'hC: return 7'h39;  4'hD: return 7'h5E;  4'hE: return 7'h79;  default: return 7'h71;
        endcase
    endfunction

    task automatic check(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s at t=%0d: got %0h expected %0h", nm, t, act, exp);
        end
    endtask

    task automatic tick(input logic r, input logic ld, input logic [15:0] v,
                        input logic [3:0] d, input logic [3:0] b);
        int slot, phase;
        logic [3:0] e_an;
        logic [6:0] e_seg;
        logic       e_dp, e_frame, dark;
        rst = r; load = ld; value = v; dp = d; blank = b;
        if (r) begin
            e_an = 4'hF; e_seg = 7'h7F; e_dp = 1'b1; e_frame = 1'b0; dark = 1'b0;
            m_value = '0; m_dp = '0; m_blank = '1;
            p_value = '0; p_dp = '0; p_blank = '1;
            m_pend = 1'b0; t = 0;
        end else begin
            slot  = (t / 4) % 4;
            phase = t % 4;
            dark  = m_blank[slot];
            e_an  = (phase == 0 || dark) ? 4'hF : 4'(~(4'b0001 << slot));
            e_seg = ~glyph_on(m_value[slot*4 +: 4]);
            e_dp  = ~m_dp[slot];
            e_frame = (t % 16 == 15);
            if (ld) begin
                p_value = v; p_dp = d; p_blank = b;
            end
            if (t % 16 == 15) begin
                if (ld) begin
                    m_value = v; m_dp = d; m_blank = b;
                end else if (m_pend) begin
                    m_value = p_value; m_dp = p_dp; m_blank = p_blank;
                end
                m_pend = 1'b0;
            end else if (ld) begin
                m_pend = 1'b1;
            end
            t++;
        end
        @(posedge clk);
        #1;
        check("an", int'(an), int'(e_an));
        if (!dark) begin
            check("seg", int'(seg), int'(e_seg));
            check("seg_dp", int'(seg_dp), int'(e_dp));
        end
        check("frame", int'(frame), int'(e_frame));
        check("pending", int'(pending), int'(m_pend));
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick(1'b0, 1'b0, 16'h0, 4'h0, 4'h0);
    endtask

    task automatic idle_until(input int ph);
        for (int i = 0; i < 16 && (t % 16) != ph; i++) idle(1);
    endtask

    initial begin
        vecs[0]  = '{4'h0, 7'h40}; vecs[1]  = '{4'h1, 7'h79};
        vecs[2]  = '{4'h2, 7'h24}; vecs[3]  = '{4'h3, 7'h30};
        vecs[4]  = '{4'h4, 7'h19}; vecs[5]  = '{4'h5, 7'h12};
        vecs[6]  = '{4'h6, 7'h02}; vecs[7]  = '{4'h7, 7'h78};
        vecs[8]  = '{4'h8, 7'h00}; vecs[9]  = '{4'h9, 7'h10};
        vecs[10] = '{4'hA, 7'h08}; vecs[11] = '{4'hB, 7'h03};
        vecs[12] = '{4'hC, 7'h46}; vecs[13] = '{4'hD, 7'h21};
        vecs[14] = '{4'hE, 7'h06}; vecs[15] = '{4'hF, 7'h0E};

        rst = 1'b1; load = 1'b0; value = '0; dp = '0; blank = '0;
        tick(1'b1, 1'b0, 16'h0, 4'h0, 4'h0);
        tick(1'b1, 1'b0, 16'h0, 4'h0, 4'h0);

        idle(40);

        idle_until(5);
        tick(1'b0, 1'b1, 16'h1A3F, 4'b0010, 4'b0000);
        idle(30);

        idle_until(3);
        tick(1'b0, 1'b1, 16'h1111, 4'b0000, 4'b0000);
        idle(4);
        tick(1'b0, 1'b1, 16'h2222, 4'b0000, 4'b0000);
        idle_until(2);
        check("two_loads_seg", int'(seg), 7'h24);
        idle(14);

        idle_until(15);
        tick(1'b0, 1'b1, 16'h5A5A, 4'b1001, 4'b0000);
        idle(2);
        check("coincident_seg", int'(seg), 7'h08);
        check("coincident_an", int'(an), 4'b1110);
        idle(16);

        idle_until(7);
        tick(1'b0, 1'b1, 16'h8888, 4'b0000, 4'b0101);
        idle(36);

        idle_until(9);
        tick(1'b1, 1'b0, 16'h0, 4'h0, 4'h0);
        idle(20);

        for (int k = 0; k < 16; k++) begin
            tick(1'b0, 1'b1, {4{vecs[k].nib}}, 4'($urandom_range(0, 15)), 4'b0000);
            for (int i = 0; i < 40 && !(m_pend == 1'b0 && (t % 16) == 2); i++) idle(1);
            check("glyph_table", int'(seg), int'(vecs[k].seg_n));
        end

        for (int i = 0; i < 800; i++) begin
            tick(($urandom_range(0, 299) == 0),
                 ($urandom_range(0, 9) == 0),
                 16'($urandom), 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
